// File: rtl/io_event_collector.sv
// rtl/io_event_collector.sv - event pulse capture, round-robin pick and ID FIFO for the SoC event unit
module io_event_collector #(
  parameter int N_EVT      = 128,
  parameter int ID_WIDTH   = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_ni,
  input  logic [N_EVT-1:0]              events_i,
  output logic                          evt_valid_o,
  output logic [ID_WIDTH-1:0]           evt_data_o,
  input  logic                          evt_ready_i,
  output logic                          lost_o,
  output logic [ID_WIDTH-1:0]           lost_id_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int PTR_W = $clog2(N_EVT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_EVT - 1);

  logic [N_EVT-1:0]    pending;
  logic [N_EVT-1:0]    grant;
  logic [N_EVT-1:0]    lost_vec;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    scan_idx;
  logic [PTR_W-1:0]    lost_idx;
  logic                grant_vld;
  logic                lost_any;
  logic                push_ok;
  logic                pop;
  logic                full;

  logic [ID_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LVL_W-1:0]    level;

  assign full         = (level == FULL_LVL);
  assign evt_valid_o  = (level != '0);
  assign evt_data_o   = mem[rd_ptr];
  assign fifo_level_o = level;
  assign pop          = evt_valid_o & evt_ready_i;
  // A pop in the same cycle frees the slot the push will use.
  assign push_ok      = !full || pop;

  // Round-robin search: first pending line at or after rr_ptr, wrapping at N_EVT.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (push_ok) begin
      for (int k = 0; k < N_EVT; k++) begin
        scan_idx = PTR_W'((int'(rr_ptr) + k) % N_EVT);
        if (!grant_vld && pending[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    grant = grant_vld ? (N_EVT'(1) << grant_idx) : '0;
  end

  // A line is lost when a new pulse lands on a still-pending, ungranted line; report the lowest.
  always_comb begin
    lost_vec = events_i & pending & ~grant;
    lost_any = 1'b0;
    lost_idx = '0;
    for (int i = N_EVT - 1; i >= 0; i--) begin
      if (lost_vec[i]) begin
        lost_any = 1'b1;
        lost_idx = PTR_W'(i);
      end
    end
  end

  // Pending lines and arbiter pointer; a new pulse wins over a same-cycle grant.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      pending <= '0;
      rr_ptr  <= '0;
    end else begin
      pending <= events_i | (pending & ~grant);
      if (grant_vld) begin
        rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
      end
    end
  end

  // Loss report: one-cycle pulse, ID held until the next loss.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      lost_o    <= 1'b0;
      lost_id_o <= '0;
    end else begin
      lost_o <= lost_any;
      if (lost_any) begin
        lost_id_o <= ID_WIDTH'(lost_idx);
      end
    end
  end

  // Output FIFO with registered storage; head is read straight from memory.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (grant_vld) begin
        mem[wr_ptr] <= ID_WIDTH'(grant_idx);
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({grant_vld, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: doc/io_event_collector.md
Name: io_event_collector

Overview:
- Sits directly downstream of the IO subsystem's per-peripheral event vector (32 channels × 4 event lines, one-cycle pulses).
- Captures every pulse in a per-line pending register and picks pending lines with a round-robin arbiter.
- Pushes the selected event IDs into a small FIFO and delivers them to the SoC event unit over a valid/ready stream.
- Reports events lost to pending-register overflow.

Parameters:
- N_EVT, 128, number of event input lines (flattened 32×4, line index = channel*4 + event).
- ID_WIDTH, 8, width of the emitted event ID; must satisfy 2^ID_WIDTH >= N_EVT.
- FIFO_DEPTH, 8, entries in the output FIFO; power of two, >= 2.

Ports:
- sys_clk_i  in  1  clock; all state on rising edge.
- sys_rst_ni  in  1  asynchronous active-low reset.
- events_i  in  N_EVT  event pulses; bit i high for one cycle per event.
- evt_valid_o  out  1  FIFO head is valid.
- evt_data_o  out  ID_WIDTH  event ID at FIFO head (zero-extended line index).
- evt_ready_i  in  1  consumer accepts the head when evt_valid_o && evt_ready_i.
- lost_o  out  1  one-cycle pulse: at least one event was dropped in the previous cycle.
- lost_id_o  out  ID_WIDTH  lowest dropped line index; updated only when lost_o pulses, otherwise held.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - pending = 0, RR pointer = 0, FIFO empty.
  - evt_valid_o = 0, evt_data_o = 0, lost_o = 0, lost_id_o = 0, fifo_level_o = 0.
  - Reset mid-operation discards all pending and queued events with no lost report.
- Pending update, per line i, each edge:
  - pending[i] <= events_i[i] | (pending[i] & ~grant[i]).
  - If set and clear coincide, set wins: the line stays pending and the new event is kept.
- Lost detection:
  - Line i is lost when events_i[i] && pending[i] && !grant[i].
  - Any lost line → lost_o = 1 in the next cycle and lost_id_o = lowest lost index.
  - No counting. Multiple lost lines in one cycle give a single pulse.
- Arbitration (combinational on pending):
  - push_ok = !full || (evt_valid_o && evt_ready_i); a simultaneous pop frees a slot.
  - If push_ok and any pending: grant the first pending index at or after the RR pointer, searching upward and wrapping N_EVT-1 → 0. At most one grant per cycle.
  - On a grant of index g: the FIFO pushes g at that edge and the pointer becomes (g+1) mod N_EVT.
  - With no grant the pointer holds.
- FIFO:
  - Registered storage; the head drives evt_data_o directly.
  - Pop on evt_valid_o && evt_ready_i.
  - Simultaneous push and pop: level unchanged, order preserved. This includes both the full and the level-1 cases.
  - Push to an empty FIFO is visible on evt_valid_o in the following cycle (no fall-through bypass).
- Latency: pulse sampled at edge E0 → pending after E0 → push at E1 → evt_valid_o high after E1, i.e. 2 cycles with an empty FIFO and no contention.
- Throughput: one event per cycle sustained when evt_ready_i is held high.
- When full with no pop: no grants; events wait in pending, bounded only by the one-pending-per-line rule.
- evt_valid_o / evt_data_o stay stable while evt_valid_o && !evt_ready_i.

Test Plan:
- Single pulse on line 5 with evt_ready_i=1 → evt_valid_o high exactly 2 cycles later with evt_data_o=0x05 for one cycle; fifo_level_o returns to 0; lost_o never asserts.
- Lines 3, 64 and 127 pulsed in the same cycle, pointer=0, ready=1 → IDs 0x03, 0x40, 0x7F on consecutive cycles; pointer ends at 0.
- Round-robin fairness: pointer forced to 65 via a prior grant of 64; lines 10 and 100 pending → 100 emitted before 10.
- Backpressure: evt_ready_i=0, pulse lines 0..9 one per cycle → fifo_level_o saturates at 8 and lines 8, 9 remain pending; raise ready → IDs 0..9 emitted in order, no loss.
- Overflow: with the FIFO full, pulse line 42 twice 3 cycles apart → lost_o pulses once, 1 cycle after the second pulse, with lost_id_o=0x2A; 42 is emitted only once after drain.
- Reset asserted asynchronously while level=4 and pending is nonzero → all outputs 0 immediately; after release, no stale IDs are emitted and the pointer is 0.
